// File: rtl/sipo_frame_ctrl.sv
// Framed serial-to-parallel receiver with a valid/ready holding register and sticky overrun.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per word and the parity_err flag.
module sipo_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    input  logic             clr_ovr
);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             start;
    logic             last_data;
    logic             complete;
`ifdef SIPO_PARITY_EN
    logic             par_bad;
`endif

    assign shifted   = {sreg[WIDTH-2:0], sin};
    assign start     = sin_valid & frame_start;
    assign last_data = (state == SHIFT) && sin_valid && !frame_start
                       && (bit_cnt == CNT_W'(WIDTH - 1));

    // With parity the data bits are already in sreg when the parity bit arrives.
`ifdef SIPO_PARITY_EN
    assign complete  = (state == PARITY) && sin_valid && !frame_start;
    assign word      = sreg;
    assign par_bad   = (^sreg) != sin;
`else
    assign complete  = last_data;
    assign word      = shifted;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // Frame assembly; frame_start restarts from any state.
            if (start) begin
                sreg    <= shifted;
                bit_cnt <= CNT_W'(1);
                state   <= SHIFT;
            end else begin
                case (state)
                    IDLE: ;
                    SHIFT: begin
                        if (sin_valid) begin
                            sreg <= shifted;
                            if (last_data) begin
`ifdef SIPO_PARITY_EN
                                bit_cnt <= CNT_W'(WIDTH);
                                state   <= PARITY;
`else
                                bit_cnt <= '0;
                                state   <= IDLE;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: begin
                        if (sin_valid) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
`endif
                    default: begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                endcase
            end

            // Holding register: accept on completion if free or being drained this edge.
            if (complete && (!pout_valid || pout_ready)) begin
                pout       <= word;
                pout_valid <= 1'b1;
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end

            if (complete && pout_valid && !pout_ready)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;

`ifdef SIPO_PARITY_EN
            if (complete && par_bad)
                parity_err <= 1'b1;
            else if (clr_ovr)
                parity_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl (WIDTH=8); parity cases run when SIPO_PARITY_EN is defined.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             sin;
    logic             sin_valid;
    logic             frame_start;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             clr_ovr;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .frame_start (frame_start),
        .pout        (pout),
        .pout_valid  (pout_valid),
        .pout_ready  (pout_ready),
        .busy        (busy),
        .bit_cnt     (bit_cnt),
        .overrun     (overrun),
`ifdef SIPO_PARITY_EN
        .parity_err  (parity_err),
`endif
        .clr_ovr     (clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b, input logic fs);
        sin         = b;
        sin_valid   = 1'b1;
        frame_start = fs;
        tick();
        sin_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sends one word MSB first with no gaps; pout_ready is driven only on the completion bit.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last);
        for (int i = WIDTH - 1; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
            if (i == 0) pout_ready = rdy_last;
`endif
            bit_in(w[i], i == WIDTH - 1);
        end
`ifdef SIPO_PARITY_EN
        pout_ready = rdy_last;
        bit_in(^w, 1'b0);
`endif
        pout_ready = 1'b0;
    endtask

    task automatic consume();
        pout_ready = 1'b1;
        tick();
        pout_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] w;

        rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
        pout_ready = 1'b0; clr_ovr = 1'b0;

        // Reset held with random activity on every input
        for (int i = 0; i < 6; i++) begin
            sin         = 1'($urandom);
            sin_valid   = 1'($urandom);
            frame_start = 1'($urandom);
            pout_ready  = 1'($urandom);
            clr_ovr     = 1'($urandom);
            tick();
        end
        check_eq("rst_pout", 32'(pout), 32'h00);
        check_eq("rst_pvalid", 32'(pout_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ovr", 32'(overrun), 0);
        check_eq("rst_cnt", 32'(bit_cnt), 0);
        sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0; pout_ready = 1'b0; clr_ovr = 1'b0;
        rst = 1'b1;
        idle(2);
        check_eq("post_rst_busy", 32'(busy), 0);
        check_eq("post_rst_pvalid", 32'(pout_valid), 0);

        // Basic word 0xAB
        w = 8'hAB;
        bit_in(w[7], 1'b1);
        check_eq("basic_cnt1", 32'(bit_cnt), 1);
        check_eq("basic_busy", 32'(busy), 1);
        for (int i = 6; i >= 1; i--) bit_in(w[i], 1'b0);
        check_eq("basic_cnt7", 32'(bit_cnt), 7);
        check_eq("basic_pvalid_early", 32'(pout_valid), 0);
        bit_in(w[0], 1'b0);
`ifdef SIPO_PARITY_EN
        check_eq("basic_par_cnt", 32'(bit_cnt), 8);
        check_eq("basic_par_pvalid", 32'(pout_valid), 0);
        bit_in(1'b1, 1'b0);
        check_eq("basic_par_err", 32'(parity_err), 0);
`endif
        check_eq("basic_pvalid", 32'(pout_valid), 1);
        check_eq("basic_pout", 32'(pout), 32'hAB);
        check_eq("basic_idle_cnt", 32'(bit_cnt), 0);
        check_eq("basic_idle_busy", 32'(busy), 0);
        idle(2);
        check_eq("basic_hold", 32'(pout), 32'hAB);
        consume();
        check_eq("basic_drained", 32'(pout_valid), 0);

        // Gapped input: same word with two idle cycles after every bit
        for (int i = 7; i >= 0; i--) begin
            bit_in(w[i], i == 7);
            idle(2);
            if (i == 5) check_eq("gap_cnt_hold", 32'(bit_cnt), 3);
        end
`ifdef SIPO_PARITY_EN
        bit_in(1'b1, 1'b0);
`endif
        check_eq("gap_pvalid", 32'(pout_valid), 1);
        check_eq("gap_pout", 32'(pout), 32'hAB);
        consume();

        // Overrun: 0x56 arrives while 0xAB is still held
        send_word(8'hAB, 1'b0);
        send_word(8'h56, 1'b0);
        check_eq("ovr_pout", 32'(pout), 32'hAB);
        check_eq("ovr_flag", 32'(overrun), 1);
        check_eq("ovr_pvalid", 32'(pout_valid), 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_eq("ovr_clr", 32'(overrun), 0);
        send_word(8'h56, 1'b1);
        check_eq("ovr_swap_pout", 32'(pout), 32'h56);
        check_eq("ovr_swap_pvalid", 32'(pout_valid), 1);
        check_eq("ovr_swap_flag", 32'(overrun), 0);

        // Clear coinciding with a new overrun: set wins
        clr_ovr = 1'b1;
        send_word(8'h11, 1'b0);
        clr_ovr = 1'b0;
        check_eq("ovr_setwins", 32'(overrun), 1);
        check_eq("ovr_setwins_pout", 32'(pout), 32'h56);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        consume();
        check_eq("ovr_clr2", 32'(overrun), 0);

        // Noise in IDLE, then a realigning frame_start after 3 bits
        for (int i = 0; i < 5; i++) bit_in(1'($urandom), 1'b0);
        check_eq("noise_busy", 32'(busy), 0);
        check_eq("noise_cnt", 32'(bit_cnt), 0);
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        check_eq("realign_cnt3", 32'(bit_cnt), 3);
        w = 8'h56;
        bit_in(w[7], 1'b1);
        check_eq("realign_cnt1", 32'(bit_cnt), 1);
        for (int i = 6; i >= 0; i--) bit_in(w[i], 1'b0);
`ifdef SIPO_PARITY_EN
        bit_in(1'b0, 1'b0);
`endif
        check_eq("realign_pout", 32'(pout), 32'h56);
        check_eq("realign_pvalid", 32'(pout_valid), 1);
        consume();

        // Back-to-back words; second completes on the same edge the first is consumed
        send_word(8'hC3, 1'b0);
        check_eq("b2b_first", 32'(pout), 32'hC3);
        send_word(8'h3C, 1'b1);
        check_eq("b2b_second", 32'(pout), 32'h3C);
        check_eq("b2b_pvalid", 32'(pout_valid), 1);
        check_eq("b2b_ovr", 32'(overrun), 0);

        // Async reset mid-word while a word is held
        for (int i = 0; i < 4; i++) bit_in(1'b1, i == 0);
        check_eq("midrst_pre_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_cnt", 32'(bit_cnt), 0);
        check_eq("midrst_pvalid", 32'(pout_valid), 0);
        check_eq("midrst_pout", 32'(pout), 32'h00);
        idle(1);
        rst = 1'b1;
        idle(1);

`ifdef SIPO_PARITY_EN
        // Parity: correct bit, then wrong bit
        w = 8'hAB;
        for (int i = 7; i >= 0; i--) bit_in(w[i], i == 7);
        bit_in(1'b1, 1'b0);
        check_eq("par_ok_pvalid", 32'(pout_valid), 1);
        check_eq("par_ok_err", 32'(parity_err), 0);
        consume();
        for (int i = 7; i >= 0; i--) bit_in(w[i], i == 7);
        bit_in(1'b0, 1'b0);
        check_eq("par_bad_err", 32'(parity_err), 1);
        check_eq("par_bad_pout", 32'(pout), 32'hAB);
        check_eq("par_bad_pvalid", 32'(pout_valid), 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_eq("par_clr", 32'(parity_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
